// File: rtl/matrix_pkg.sv
// matrix_pkg: shared FSM state type and element/index width helpers for the matrix blocks
package matrix_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int elem_w(input int bits);
    return 2 * bits;
  endfunction
endpackage

// File: rtl/matrix_res_reader_if.sv
// matrix_res_reader_if: start/ready/valid element stream bundle; master = reader, slave = consumer
interface matrix_res_reader_if
  import matrix_pkg::*;
#(
  parameter int BITS = 8,
  parameter int HEIGHT_A = 2,
  parameter int WIDTH_B = 3
);
  logic start, ready, valid, last, busy, done;
  logic [elem_w(BITS)-1:0] data;
  logic [idx_w(HEIGHT_A)-1:0] row;
  logic [idx_w(WIDTH_B)-1:0] col;
  modport master(input start, ready, output valid, data, row, col, last, busy, done);
  modport slave(output start, ready, input valid, data, row, col, last, busy, done);
endinterface

// File: rtl/matrix_idx_counter.sv
// matrix_idx_counter: row-major row/col counter with wrap and last flag; clr zeroes, en advances, holds at last
module matrix_idx_counter
  import matrix_pkg::*;
#(
  parameter int HEIGHT_A = 2,
  parameter int WIDTH_B = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  output logic [idx_w(HEIGHT_A)-1:0]  row,
  output logic [idx_w(WIDTH_B)-1:0]   col,
  output logic                        last
);
  localparam int RW = idx_w(HEIGHT_A);
  localparam int CW = idx_w(WIDTH_B);
  logic col_end;
  always_comb begin
    col_end = col == CW'(WIDTH_B - 1);
    last = col_end && (row == RW'(HEIGHT_A - 1));
  end
  // Holding at the last index keeps o_data on the final element after the stream ends.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en && !last) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= col_end ? row + 1'b1 : row;
    end
endmodule

// File: rtl/matrix_res_reader.sv
// matrix_res_reader: snapshots a parallel result matrix and streams it row-major over valid/ready
// Ports: clk, reset (async active-low), i_start, i_array_res, i_ready -> o_valid, o_data, o_row,
// o_col, o_last, o_busy, o_done; o_checksum only when MATRIX_RES_READER_CHECKSUM_EN is defined.
module matrix_res_reader
  import matrix_pkg::*;
#(
  parameter int BITS = 8,
  parameter int HEIGHT_A = 2,
  parameter int WIDTH_B = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic [elem_w(BITS)-1:0]     i_array_res [HEIGHT_A][WIDTH_B],
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic [elem_w(BITS)-1:0]     o_data,
  output logic [idx_w(HEIGHT_A)-1:0]  o_row,
  output logic [idx_w(WIDTH_B)-1:0]   o_col,
  output logic                        o_last,
  output logic                        o_busy,
`ifdef MATRIX_RES_READER_CHECKSUM_EN
  output logic [elem_w(BITS)-1:0]     o_checksum,
`endif
  output logic                        o_done
);
  state_t state;
  logic [elem_w(BITS)-1:0] mem [HEIGHT_A][WIDTH_B];
  logic start, xfer, last;
  always_comb begin
    start = state == IDLE && i_start;
    o_valid = state == STREAM;
    o_busy = state != IDLE;
    o_done = state == DONE;
    o_last = o_valid && last;
    xfer = o_valid && i_ready;
    o_data = mem[o_row][o_col];
  end
  matrix_idx_counter #(.HEIGHT_A(HEIGHT_A), .WIDTH_B(WIDTH_B)) u_idx (
    .clk(clk),
    .reset(reset),
    .clr(start),
    .en(xfer),
    .row(o_row),
    .col(o_col),
    .last(last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= start ? STREAM : (xfer && last) ? DONE : state == DONE ? IDLE : state;
  // Zeroing the buffer on reset makes o_data read 0 at index [0][0].
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem <= '{default: '0};
    else if (start) mem <= i_array_res;
`ifdef MATRIX_RES_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) o_checksum <= '0;
    else if (start) o_checksum <= '0;
    else if (xfer) o_checksum <= o_checksum + o_data;
`endif
endmodule

// File: tb/tb_matrix_res_reader.sv
// tb_matrix_res_reader: directed self-checking bench for matrix_res_reader
module tb_matrix_res_reader;
  import matrix_pkg::*;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  logic [15:0] mat [2][3];
  logic [15:0] exp_v [6];
  int checks = 0;
  int failures = 0;
  matrix_res_reader_if #(.BITS(8), .HEIGHT_A(2), .WIDTH_B(3)) bus ();
`ifdef MATRIX_RES_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  matrix_res_reader #(.BITS(8), .HEIGHT_A(2), .WIDTH_B(3)) dut (
    .clk(clk),
    .reset(reset),
    .i_start(bus.start),
    .i_array_res(mat),
    .i_ready(bus.ready),
    .o_valid(bus.valid),
    .o_data(bus.data),
    .o_row(bus.row),
    .o_col(bus.col),
    .o_last(bus.last),
    .o_busy(bus.busy),
`ifdef MATRIX_RES_READER_CHECKSUM_EN
    .o_checksum(checksum),
`endif
    .o_done(bus.done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_std;
    mat = '{'{16'd54, 16'd66, 16'd78}, '{16'd90, 16'd111, 16'd132}};
  endtask

  task automatic test_reset;
    bus.start = 0;
    bus.ready = 0;
    load_std();
    exp_v = '{16'd54, 16'd66, 16'd78, 16'd90, 16'd111, 16'd132};
    tick();
    tick();
    checks++;
    if ({bus.valid, bus.data, bus.row, bus.col, bus.last, bus.busy, bus.done} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%0d row=%0d col=%0d last=%b busy=%b done=%b want all 0",
               bus.valid, bus.data, bus.row, bus.col, bus.last, bus.busy, bus.done);
    end
    reset = 1;
    tick();
    checks++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got valid=%b busy=%b done=%b want 000", bus.valid, bus.busy, bus.done);
    end
  endtask

  task automatic test_stream;
    bus.ready = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus.valid, bus.last, bus.row, bus.col, bus.data} !== {1'b1, 1'(k == 5), 1'(k / 3), 2'(k % 3), exp_v[k]}) begin
        failures++;
        $display("FAIL stream_elem%0d got valid=%b last=%b row=%0d col=%0d data=%0d want 1 %b %0d %0d %0d",
                 k, bus.valid, bus.last, bus.row, bus.col, bus.data, k == 5, k / 3, k % 3, exp_v[k]);
      end
      tick();
    end
    checks++;
    if ({bus.valid, bus.busy, bus.done} !== 3'b011) begin
      failures++;
      $display("FAIL stream_done got valid=%b busy=%b done=%b want 011", bus.valid, bus.busy, bus.done);
    end
`ifdef MATRIX_RES_READER_CHECKSUM_EN
    checks++;
    if (checksum !== 16'd531) begin
      failures++;
      $display("FAIL checksum_std got %0d want 531", checksum);
    end
`endif
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.valid, bus.data} !== {3'b000, 16'd132}) begin
      failures++;
      $display("FAIL stream_idle got busy=%b done=%b valid=%b data=%0d want 0 0 0 132",
               bus.busy, bus.done, bus.valid, bus.data);
    end
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int cyc = 0;
    bit got_done = 0;
    bus.ready = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    while (!got_done && cyc < 60) begin
      bus.ready = (cyc % 3 == 0);
      if (bus.valid) begin
        checks++;
        if (idx > 5) begin
          failures++;
          $display("FAIL bp_extra got extra element data=%0d want none", bus.data);
        end else if ({bus.row, bus.col, bus.data} !== {1'(idx / 3), 2'(idx % 3), exp_v[idx]}) begin
          failures++;
          $display("FAIL bp_elem%0d got row=%0d col=%0d data=%0d want %0d %0d %0d",
                   idx, bus.row, bus.col, bus.data, idx / 3, idx % 3, exp_v[idx]);
        end
        if (bus.ready) idx++;
      end
      if (bus.done) got_done = 1;
      tick();
      cyc++;
    end
    checks++;
    if (!got_done || idx != 6) begin
      failures++;
      $display("FAIL bp_count got transfers=%0d done=%b want 6 1", idx, got_done);
    end
    bus.ready = 1;
    tick();
  endtask

  task automatic test_snapshot;
    load_std();
    bus.ready = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
    mat = '{default: 16'hFFFB};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus.valid, bus.data} !== {1'b1, exp_v[k]}) begin
        failures++;
        $display("FAIL snap_elem%0d got valid=%b data=%0d want 1 %0d", k, bus.valid, bus.data, exp_v[k]);
      end
      tick();
    end
    tick();
    load_std();
  endtask

  task automatic test_start_held;
    bit got_done = 0;
    bus.ready = 1;
    bus.start = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus.valid, bus.data} !== {1'b1, exp_v[k]}) begin
        failures++;
        $display("FAIL held_elem%0d got valid=%b data=%0d want 1 %0d", k, bus.valid, bus.data, exp_v[k]);
      end
      tick();
    end
    checks++;
    if ({bus.valid, bus.done} !== 2'b01) begin
      failures++;
      $display("FAIL held_done got valid=%b done=%b want 0 1", bus.valid, bus.done);
    end
    tick();
    checks++;
    if ({bus.busy, bus.valid} !== 2'b00) begin
      failures++;
      $display("FAIL held_idle got busy=%b valid=%b want 0 0", bus.busy, bus.valid);
    end
    tick();
    checks++;
    if ({bus.valid, bus.row, bus.col, bus.data} !== {1'b1, 1'b0, 2'd0, 16'd54}) begin
      failures++;
      $display("FAIL held_restart got valid=%b row=%0d col=%0d data=%0d want 1 0 0 54",
               bus.valid, bus.row, bus.col, bus.data);
    end
    bus.start = 0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      tick();
      got_done = bus.done;
    end
    checks++;
    if (!got_done) begin
      failures++;
      $display("FAIL held_drain got done=0 want 1");
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bit got_done = 0;
    bus.ready = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
    tick();
    tick();
    tick();
    checks++;
    if ({bus.valid, bus.data} !== {1'b1, 16'd90}) begin
      failures++;
      $display("FAIL mid_pre got valid=%b data=%0d want 1 90", bus.valid, bus.data);
    end
    reset = 0;
    #1;
    checks++;
    if ({bus.valid, bus.data, bus.row, bus.col, bus.last, bus.busy, bus.done} !== 22'd0) begin
      failures++;
      $display("FAIL mid_reset got valid=%b data=%0d row=%0d col=%0d last=%b busy=%b done=%b want all 0",
               bus.valid, bus.data, bus.row, bus.col, bus.last, bus.busy, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) got_done = 1;
    end
    checks++;
    if (got_done) begin
      failures++;
      $display("FAIL mid_no_done got done pulse want none");
    end
    reset = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
    checks++;
    if ({bus.valid, bus.row, bus.col, bus.data} !== {1'b1, 1'b0, 2'd0, 16'd54}) begin
      failures++;
      $display("FAIL mid_restart got valid=%b row=%0d col=%0d data=%0d want 1 0 0 54",
               bus.valid, bus.row, bus.col, bus.data);
    end
    repeat (6) tick();
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart_done got done=%b want 1", bus.done);
    end
    tick();
  endtask

`ifdef MATRIX_RES_READER_CHECKSUM_EN
  task automatic test_checksum_wrap;
    mat = '{default: 16'hFFFB};
    bus.ready = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
    checks++;
    if (checksum !== 16'd0) begin
      failures++;
      $display("FAIL checksum_clear got %0d want 0", checksum);
    end
    repeat (6) tick();
    checks++;
    if ({bus.done, checksum} !== {1'b1, 16'hFFE2}) begin
      failures++;
      $display("FAIL checksum_wrap got done=%b sum=%h want 1 ffe2", bus.done, checksum);
    end
    tick();
    load_std();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_snapshot();
    test_start_held();
    test_reset_mid();
`ifdef MATRIX_RES_READER_CHECKSUM_EN
    test_checksum_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix_res_reader.md
MATRIX_RES_READER -- requirements
Module: matrix_res_reader

Interface
REQ-001 SHALL have parameter BITS, default 8, the input element width; result elements are 2*BITS wide.
REQ-002 SHALL have parameter HEIGHT_A, default 2, the number of result rows.
REQ-003 SHALL have parameter WIDTH_B, default 3, the number of result columns.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  input  1  request to snapshot and stream the result matrix.
REQ-007 SHALL have port i_array_res  input  [2*BITS-1:0] x [HEIGHT_A][WIDTH_B]  the parallel result matrix from matrix_mul.
REQ-008 SHALL have port i_ready  input  1  downstream accepts the current element.
REQ-009 SHALL have port o_valid  output  1  o_data holds a valid element.
REQ-010 SHALL have port o_data  output  2*BITS  the current element, as raw bits with no sign interpretation.
REQ-011 SHALL have port o_row  output  $clog2(HEIGHT_A) (min 1)  the row index of o_data.
REQ-012 SHALL have port o_col  output  $clog2(WIDTH_B) (min 1)  the column index of o_data.
REQ-013 SHALL have port o_last  output  1  o_data is element [HEIGHT_A-1][WIDTH_B-1].
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse after the last element is transferred.

Function
REQ-016 SHALL implement the states IDLE, STREAM and DONE.
REQ-017 SHALL, in IDLE, on a rising edge with i_start=1, copy all of i_array_res into an internal buffer, set row=0 and col=0, and enter STREAM.
REQ-018 SHALL drive o_valid=1 in the first cycle after the start edge, i.e. one cycle of latency, with o_data=buffer[0][0].
REQ-019 SHALL treat a transfer as o_valid & i_ready sampled at a rising edge.
REQ-020 SHALL, on each transfer, increment col; when col=WIDTH_B-1, wrap col to 0 and increment row (row-major order).
REQ-021 SHALL hold o_data, o_row, o_col and o_last stable while o_valid=1 and i_ready=0.
REQ-022 SHALL drive o_last=1 exactly when row=HEIGHT_A-1 and col=WIDTH_B-1 in STREAM.
REQ-023 SHALL, on a transfer with o_last=1, enter DONE; DONE SHALL assert o_done for one cycle with o_valid=0, then return to IDLE.
REQ-024 SHALL ignore i_start in STREAM and DONE, and SHALL NOT modify the buffer in those states.
REQ-025 SHALL hold o_valid=0 in IDLE and DONE; o_data SHALL keep its last value when o_valid=0.
REQ-026 SHALL stream with no gap cycles between elements when i_ready is held at 1: HEIGHT_A*WIDTH_B consecutive valid cycles.
REQ-027 SHALL let changes on i_array_res after the snapshot have no effect on the stream.

Reset
REQ-028 SHALL, while reset=0, force state=IDLE, row=0, col=0 and o_valid, o_data, o_row, o_col, o_last, o_busy and o_done to 0.
REQ-029 SHALL, on reset assertion mid-STREAM, abort immediately with no o_done pulse; buffer contents are don't-care.
REQ-030 SHALL accept a start from IDLE on the first rising edge after reset deassertion.

Configuration
REQ-031 SHALL, with macro MATRIX_RES_READER_CHECKSUM_EN defined, add output o_checksum (2*BITS), cleared on start and on reset, accumulating the unsigned sum modulo 2^(2*BITS) of each transferred o_data, and stable and valid in the o_done cycle.
REQ-032 SHALL, without MATRIX_RES_READER_CHECKSUM_EN, not have the o_checksum port or the accumulator logic.

Structure
REQ-033 SHALL take the state enum typedef (IDLE/STREAM/DONE) from shared package matrix_pkg.
REQ-034 SHALL take any element-width and index-width constants or functions from matrix_pkg.
REQ-035 SHALL instantiate sub-module matrix_idx_counter, a row/col counter with wrap and last flag, parameterised by HEIGHT_A and WIDTH_B.

Verification
REQ-036 Default params; i_array_res={54,66,78;90,111,132}; i_start pulse; i_ready=1 -> o_data 54,66,78,90,111,132 on six consecutive cycles starting one cycle after start; o_last on 132; o_done the next cycle.
REQ-037 Same matrix; i_ready toggling 1,0,0,1,... -> each element held while i_ready=0; order unchanged; no duplicates or drops.
REQ-038 Start, then change i_array_res to all 0xFFFB after the start edge -> streamed values are still 54..132.
REQ-039 i_start held at 1 throughout -> one complete stream, o_done, IDLE, then a new stream begins; no restart mid-stream.
REQ-040 reset=0 after the third transfer -> all outputs 0 immediately, no o_done; a new start streams from [0][0].
REQ-041 With MATRIX_RES_READER_CHECKSUM_EN defined, run the REQ-036 matrix -> o_checksum=531 in the o_done cycle; for the matrix {0xFFFB,...} verify modulo-2^16 wrap.
